// File: rtl/risc_datapath.sv
// ---------------------------------------------------------------------------
// risc_datapath -- 16-bit execution datapath of the Simple RISC Machine.
//
// Holds an 8x16 register file (instance REGFILE, registers R0..R7), the A/B
// operand registers, a one-bit shifter on the B path, the operand muxes, a
// four-operation ALU, the C result register and the Z/N/V status register.
// Every control input is driven by the controller FSM.
//
// Ports:
//   clk          rising-edge clock for all state
//   rst_n        asynchronous active-low reset (clears all state)
//   mdata        memory read data          (write-back source, vsel=00)
//   sximm8       sign-extended imm8        (write-back source, vsel=01)
//   PC           program counter           (write-back source, vsel=10)
//   sximm5       sign-extended imm5        (ALU B operand when bsel=1)
//   vsel         write-back select (11 selects datapath_out)
//   writenum     register write index,  write = write enable
//   readnum      register read index
//   loada/loadb  load enables for A and B
//   shift        00 none, 01 LSL1, 10 LSR1, 11 ASR1 (applied to B)
//   asel/bsel    operand muxes (asel=1 -> Ain=0, bsel=1 -> Bin=sximm5)
//   ALUop        00 add, 01 sub, 10 AND, 11 NOT B
//   loadc/loads  load enables for C and the status register
//   datapath_out contents of C
//   Z_out/N_out/V_out registered zero / negative / signed-overflow flags
//
// Build option:
//   DATAPATH_WRITE_BYPASS_EN -- when defined, a read of the index being
//   written in the same cycle returns the incoming write data instead of
//   the stored value.
// ---------------------------------------------------------------------------

module risc_datapath_regfile #(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] data_in,
   input  logic [2:0]        writenum,
   input  logic              write,
   input  logic [2:0]        readnum,
   output logic [DATA_W-1:0] data_out
);

   logic [DATA_W-1:0] R0, R1, R2, R3, R4, R5, R6, R7;
   logic [DATA_W-1:0] stored_rd;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         R0 <= '0; R1 <= '0; R2 <= '0; R3 <= '0;
         R4 <= '0; R5 <= '0; R6 <= '0; R7 <= '0;
      end else if (write) begin
         case (writenum)
            3'd0:    R0 <= data_in;
            3'd1:    R1 <= data_in;
            3'd2:    R2 <= data_in;
            3'd3:    R3 <= data_in;
            3'd4:    R4 <= data_in;
            3'd5:    R5 <= data_in;
            3'd6:    R6 <= data_in;
            default: R7 <= data_in;
         endcase
      end
   end

   always_comb begin
      stored_rd = R0;
      case (readnum)
         3'd0:    stored_rd = R0;
         3'd1:    stored_rd = R1;
         3'd2:    stored_rd = R2;
         3'd3:    stored_rd = R3;
         3'd4:    stored_rd = R4;
         3'd5:    stored_rd = R5;
         3'd6:    stored_rd = R6;
         default: stored_rd = R7;
      endcase
   end

`ifdef DATAPATH_WRITE_BYPASS_EN
   // Write-through forwarding: same-cycle read of the write target sees the new value.
   assign data_out = (write && (readnum == writenum)) ? data_in : stored_rd;
`else
   assign data_out = stored_rd;
`endif

endmodule

module risc_datapath #(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] mdata,
   input  logic [DATA_W-1:0] sximm8,
   input  logic [DATA_W-1:0] PC,
   input  logic [DATA_W-1:0] sximm5,
   input  logic [1:0]        vsel,
   input  logic [2:0]        writenum,
   input  logic              write,
   input  logic [2:0]        readnum,
   input  logic              loada,
   input  logic              loadb,
   input  logic [1:0]        shift,
   input  logic              asel,
   input  logic              bsel,
   input  logic [1:0]        ALUop,
   input  logic              loadc,
   input  logic              loads,
   output logic [DATA_W-1:0] datapath_out,
   output logic              Z_out,
   output logic              N_out,
   output logic              V_out
);

   localparam int MSB = DATA_W - 1;

   logic [DATA_W-1:0]        wb_data;
   logic [DATA_W-1:0]        rd_data;
   logic [DATA_W-1:0]        a_q, b_q, c_q;
   logic                     z_q, n_q, v_q;
   logic [DATA_W-1:0]        b_shifted;
   logic signed [DATA_W-1:0] ain_s, bin_s, alu_d;
   logic                     z_d, n_d, v_d;

   // Signed overflow: add overflows when like-signed operands give an
   // opposite-signed result; sub when operand signs differ and the result
   // sign departs from Ain. Logic ops never overflow.
   function automatic logic ovf_f(input logic [1:0]              op,
                                  input logic signed [DATA_W-1:0] a,
                                  input logic signed [DATA_W-1:0] b,
                                  input logic signed [DATA_W-1:0] r);
      case (op)
         2'b00:   ovf_f = (a[MSB] == b[MSB]) && (r[MSB] != a[MSB]);
         2'b01:   ovf_f = (a[MSB] != b[MSB]) && (r[MSB] != a[MSB]);
         default: ovf_f = 1'b0;
      endcase
   endfunction

   // ---- write-back mux and register file -----------------------------------
   always_comb begin
      wb_data = mdata;
      case (vsel)
         2'b00:   wb_data = mdata;
         2'b01:   wb_data = sximm8;
         2'b10:   wb_data = PC;
         default: wb_data = c_q;
      endcase
   end

   risc_datapath_regfile #(.DATA_W(DATA_W)) REGFILE (
      .clk      (clk),
      .rst_n    (rst_n),
      .data_in  (wb_data),
      .writenum (writenum),
      .write    (write),
      .readnum  (readnum),
      .data_out (rd_data)
   );

   // ---- stage 1: register read -> A / B ------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q <= '0;
         b_q <= '0;
      end else begin
         if (loada) a_q <= rd_data;
         if (loadb) b_q <= rd_data;
      end
   end

   always_comb begin
      b_shifted = b_q;
      case (shift)
         2'b01:   b_shifted = {b_q[MSB-1:0], 1'b0};
         2'b10:   b_shifted = {1'b0, b_q[MSB:1]};
         2'b11:   b_shifted = {b_q[MSB], b_q[MSB:1]};
         default: b_shifted = b_q;
      endcase
   end

   assign ain_s = asel ? '0 : $signed(a_q);
   assign bin_s = bsel ? $signed(sximm5) : $signed(b_shifted);

   always_comb begin
      alu_d = ain_s + bin_s;
      case (ALUop)
         2'b00:   alu_d = ain_s + bin_s;
         2'b01:   alu_d = ain_s - bin_s;
         2'b10:   alu_d = ain_s & bin_s;
         default: alu_d = ~bin_s;
      endcase
   end

   assign z_d = (alu_d == '0);
   assign n_d = alu_d[MSB];
   assign v_d = ovf_f(ALUop, ain_s, bin_s, alu_d);

   // ---- stage 2: ALU -> C / status -----------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         c_q <= '0;
         z_q <= 1'b0;
         n_q <= 1'b0;
         v_q <= 1'b0;
      end else begin
         if (loadc) c_q <= alu_d;
         if (loads) begin
            z_q <= z_d;
            n_q <= n_d;
            v_q <= v_d;
         end
      end
   end

   assign datapath_out = c_q;
   assign Z_out        = z_q;
   assign N_out        = n_q;
   assign V_out        = v_q;

endmodule

// File: tb/tb_risc_datapath.sv
// ---------------------------------------------------------------------------
// tb_risc_datapath -- scoreboard bench for risc_datapath.
// The driver applies one control word per cycle, advances an arithmetic
// reference model and queues the expected post-edge state; the monitor pops
// one entry after each rising edge and compares C, the flags and R0..R7.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_risc_datapath;

   typedef struct packed {
      logic [15:0] mdata;
      logic [15:0] sximm8;
      logic [15:0] pc;
      logic [15:0] sximm5;
      logic [1:0]  vsel;
      logic [2:0]  writenum;
      logic        write;
      logic [2:0]  readnum;
      logic        loada;
      logic        loadb;
      logic [1:0]  shift;
      logic        asel;
      logic        bsel;
      logic [1:0]  aluop;
      logic        loadc;
      logic        loads;
   } ctrl_t;

   typedef struct packed {
      logic [15:0]      c;
      logic             z;
      logic             n;
      logic             v;
      logic [7:0][15:0] r;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] mdata, sximm8, PC, sximm5;
   logic [1:0]  vsel, shift, ALUop;
   logic [2:0]  writenum, readnum;
   logic        write, loada, loadb, asel, bsel, loadc, loads;
   logic [15:0] datapath_out;
   logic        Z_out, N_out, V_out;

   int n_cmp = 0;
   int n_bad = 0;

   exp_t sb_q[$];

   // reference model state
   int m_rf[8];
   int m_a, m_b, m_c;
   int m_z, m_n, m_v;

   always #5 clk = ~clk;

   risc_datapath dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .mdata        (mdata),
      .sximm8       (sximm8),
      .PC           (PC),
      .sximm5       (sximm5),
      .vsel         (vsel),
      .writenum     (writenum),
      .write        (write),
      .readnum      (readnum),
      .loada        (loada),
      .loadb        (loadb),
      .shift        (shift),
      .asel         (asel),
      .bsel         (bsel),
      .ALUop        (ALUop),
      .loadc        (loadc),
      .loads        (loads),
      .datapath_out (datapath_out),
      .Z_out        (Z_out),
      .N_out        (N_out),
      .V_out        (V_out)
   );

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int to_signed(input int u);
      return (u >= 32768) ? u - 65536 : u;
   endfunction

   function automatic ctrl_t idle();
      ctrl_t c;
      c = '0;
      return c;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_rf[i] = 0;
      m_a = 0; m_b = 0; m_c = 0; m_z = 0; m_n = 0; m_v = 0;
   endtask

   // One clock of the architecture, computed from the instruction-level rules.
   task automatic model_step(input ctrl_t c);
      int din, dout, bsh, ain, bin, sa, sb, full, res, sres, v;
      exp_t e;
      case (c.vsel)
         2'b00:   din = int'(c.mdata);
         2'b01:   din = int'(c.sximm8);
         2'b10:   din = int'(c.pc);
         default: din = m_c;
      endcase
      dout = m_rf[c.readnum];
`ifdef DATAPATH_WRITE_BYPASS_EN
      if (c.write && c.readnum == c.writenum) dout = din;
`endif
      case (c.shift)
         2'b01: bsh = (m_b * 2) % 65536;
         2'b10: bsh = m_b / 2;
         2'b11: begin
            sb  = to_signed(m_b);
            bsh = (sb < 0 && (sb % 2) != 0) ? (sb / 2) - 1 : sb / 2;   // floor(sb/2)
            bsh = (bsh + 65536) % 65536;
         end
         default: bsh = m_b;
      endcase
      ain = c.asel ? 0 : m_a;
      bin = c.bsel ? int'(c.sximm5) : bsh;
      sa  = to_signed(ain);
      sb  = to_signed(bin);
      v   = 0;
      case (c.aluop)
         2'b00: begin
            full = ain + bin;
            res  = full % 65536;
            sres = sa + sb;
            v    = (sres > 32767 || sres < -32768) ? 1 : 0;
         end
         2'b01: begin
            full = ain - bin;
            res  = (full + 65536) % 65536;
            sres = sa - sb;
            v    = (sres > 32767 || sres < -32768) ? 1 : 0;
         end
         2'b10:   res = ain & bin;
         default: res = 65535 - bin;
      endcase
      if (c.write) m_rf[c.writenum] = din;
      if (c.loada) m_a = dout;
      if (c.loadb) m_b = dout;
      if (c.loadc) m_c = res;
      if (c.loads) begin
         m_z = (res == 0) ? 1 : 0;
         m_n = (res >= 32768) ? 1 : 0;
         m_v = v;
      end
      e.c = 16'(m_c);
      e.z = (m_z != 0);
      e.n = (m_n != 0);
      e.v = (m_v != 0);
      for (int i = 0; i < 8; i++) e.r[i] = 16'(m_rf[i]);
      sb_q.push_back(e);
   endtask

   task automatic drive(input ctrl_t c);
      mdata = c.mdata; sximm8 = c.sximm8; PC = c.pc; sximm5 = c.sximm5;
      vsel = c.vsel; writenum = c.writenum; write = c.write; readnum = c.readnum;
      loada = c.loada; loadb = c.loadb; shift = c.shift; asel = c.asel;
      bsel = c.bsel; ALUop = c.aluop; loadc = c.loadc; loads = c.loads;
   endtask

   task automatic step(input ctrl_t c);
      drive(c);
      model_step(c);
      @(negedge clk);
   endtask

   task automatic wr(input int r, input logic [1:0] vs, input logic [15:0] val);
      ctrl_t c;
      c = idle();
      c.vsel = vs; c.writenum = 3'(r); c.write = 1'b1;
      c.mdata = val; c.sximm8 = val; c.pc = val;
      step(c);
   endtask

   task automatic ld(input int r, input logic la, input logic lb);
      ctrl_t c;
      c = idle();
      c.readnum = 3'(r); c.loada = la; c.loadb = lb;
      step(c);
   endtask

   task automatic exe(input logic [1:0] sh, input logic as, input logic bs,
                      input logic [1:0] op, input logic [15:0] imm5);
      ctrl_t c;
      c = idle();
      c.shift = sh; c.asel = as; c.bsel = bs; c.aluop = op; c.sximm5 = imm5;
      c.loadc = 1'b1; c.loads = 1'b1;
      step(c);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_C"}, int'(datapath_out), 0);
      check({tag, "_Z"}, int'(Z_out), 0);
      check({tag, "_N"}, int'(N_out), 0);
      check({tag, "_V"}, int'(V_out), 0);
      check({tag, "_R0"}, int'(dut.REGFILE.R0), 0);
      check({tag, "_R7"}, int'(dut.REGFILE.R7), 0);
   endtask

   // Monitor: one queued expectation per rising edge.
   always @(posedge clk) begin
      exp_t e;
      logic [7:0][15:0] act_r;
      #1;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         act_r = {dut.REGFILE.R7, dut.REGFILE.R6, dut.REGFILE.R5, dut.REGFILE.R4,
                  dut.REGFILE.R3, dut.REGFILE.R2, dut.REGFILE.R1, dut.REGFILE.R0};
         check("datapath_out", int'(datapath_out), int'(e.c));
         check("Z_out", int'(Z_out), int'(e.z));
         check("N_out", int'(N_out), int'(e.n));
         check("V_out", int'(V_out), int'(e.v));
         for (int i = 0; i < 8; i++)
            check($sformatf("R%0d", i), int'(act_r[i]), int'(e.r[i]));
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      ctrl_t c;
      drive(idle());
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;

      // shifted add, then write-back through vsel=11
      wr(0, 2'b01, 16'd7);
      wr(1, 2'b01, 16'd2);
      ld(0, 1'b0, 1'b1);
      ld(1, 1'b1, 1'b0);
      exe(2'b01, 1'b0, 1'b0, 2'b00, 16'd0);
      wr(2, 2'b11, 16'd0);
      ld(2, 1'b0, 1'b1);
      exe(2'b00, 1'b1, 1'b0, 2'b00, 16'd0);

      // AND with ASR
      wr(3, 2'b00, 16'h1E1E);
      wr(4, 2'b00, 16'hF0F0);
      ld(3, 1'b0, 1'b1);
      ld(4, 1'b1, 1'b0);
      exe(2'b11, 1'b0, 1'b0, 2'b10, 16'd0);

      // subtract and write-back
      wr(1, 2'b01, 16'h0017);
      wr(2, 2'b01, 16'h0005);
      ld(1, 1'b1, 1'b0);
      ld(2, 1'b0, 1'b1);
      exe(2'b00, 1'b0, 1'b0, 2'b01, 16'd0);
      wr(3, 2'b11, 16'd0);

      // LSR / LSL combos
      wr(5, 2'b01, 16'd6);
      wr(6, 2'b01, 16'd12);
      ld(5, 1'b1, 1'b0);
      ld(6, 1'b0, 1'b1);
      exe(2'b10, 1'b0, 1'b0, 2'b01, 16'd0);
      wr(5, 2'b01, 16'd2);
      wr(6, 2'b01, 16'd4);
      ld(5, 1'b1, 1'b0);
      ld(6, 1'b0, 1'b1);
      exe(2'b01, 1'b0, 1'b0, 2'b00, 16'd0);

      // logic ops
      wr(0, 2'b00, 16'hC365);
      wr(7, 2'b00, 16'hF613);
      ld(0, 1'b1, 1'b0);
      ld(7, 1'b0, 1'b1);
      exe(2'b00, 1'b0, 1'b0, 2'b10, 16'd0);
      exe(2'b00, 1'b1, 1'b0, 2'b11, 16'd0);

      // sources mdata / PC, then signed overflow
      wr(3, 2'b00, 16'd0);
      wr(4, 2'b10, 16'd0);
      ld(3, 1'b1, 1'b0);
      ld(4, 1'b0, 1'b1);
      exe(2'b00, 1'b0, 1'b0, 2'b00, 16'd0);
      wr(5, 2'b00, 16'h7FFF);
      wr(6, 2'b01, 16'd1);
      ld(5, 1'b1, 1'b0);
      ld(6, 1'b0, 1'b1);
      exe(2'b00, 1'b0, 1'b0, 2'b00, 16'd0);

      // immediate operand with both loads in one cycle
      ld(6, 1'b1, 1'b1);
      exe(2'b00, 1'b0, 1'b1, 2'b01, 16'hFFF0);

      // asynchronous reset mid-cycle, then held across an edge
      #3;
      rst_n = 1'b0;
      #1;
      check_all_zero("async_rst");
      model_reset();
      @(negedge clk);
      check_all_zero("held_rst");
      rst_n = 1'b1;

      // randomized operation
      for (int k = 0; k < 600; k++) begin
         logic [7:0] i8;
         logic [4:0] i5;
         c = idle();
         i8 = 8'($urandom);
         i5 = 5'($urandom);
         c.mdata    = 16'($urandom);
         c.pc       = 16'($urandom);
         c.sximm8   = {{8{i8[7]}}, i8};
         c.sximm5   = {{11{i5[4]}}, i5};
         c.vsel     = 2'($urandom);
         c.writenum = 3'($urandom);
         c.write    = ($urandom_range(0, 2) == 0);
         c.readnum  = 3'($urandom);
         c.loada    = 1'($urandom);
         c.loadb    = 1'($urandom);
         c.shift    = 2'($urandom);
         c.asel     = ($urandom_range(0, 3) == 0);
         c.bsel     = ($urandom_range(0, 3) == 0);
         c.aluop    = 2'($urandom);
         c.loadc    = 1'($urandom);
         c.loads    = 1'($urandom);
         step(c);
      end

      drive(idle());
      repeat (3) @(negedge clk);
      n_cmp++;
      if (sb_q.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
